// File: rtl/tx_burst_sequencer.sv
// tx_burst_sequencer
//   Transmit-side sequencer for the ultrasonic ranging chain. A ranging cycle
//   drives a burst of complementary carrier pulses (each half-period opens
//   with a dead time), then holds a listen window. The block owns the 14-bit
//   TIME base shared with the echo detector.
//
//   Optional feature macro: TOF_CAPTURE_EN
//     When defined, adds DETECTION/TOF/TOF_VALID and captures the TIME of the
//     first detection in each ranging cycle. When undefined those ports and
//     their logic are absent.
//
//   All outputs are registered; each output flop is loaded from a decode of
//   the next-state values, so outputs line up with the state they describe.
module tx_burst_sequencer #(
  parameter int HALF_PERIOD = 625,
  parameter int DEAD_TIME   = 10,
  parameter int TICK_DIV    = 500,
  parameter int LISTEN_LEN  = 16383
) (
  input  logic        SYS_CLK,
  input  logic        RST,
  input  logic        START,
  input  logic        AUTO_REPEAT,
  input  logic [4:0]  BURST_LEN,
  output logic        TX_P,
  output logic        TX_N,
  output logic        TX_ACTIVE,
  output logic        BUSY,
  output logic [13:0] TIME,
  output logic        SAMPLE_TICK,
  output logic        DONE
`ifdef TOF_CAPTURE_EN
  ,
  input  logic        DETECTION,
  output logic [13:0] TOF,
  output logic        TOF_VALID
`endif
);

  localparam int HP_W  = $clog2(HALF_PERIOD + 1);
  localparam int DIV_W = $clog2(TICK_DIV + 1);

  localparam logic [HP_W-1:0]  HP_LAST    = HP_W'(HALF_PERIOD - 1);
  localparam logic [HP_W-1:0]  DEAD_CNT   = HP_W'(DEAD_TIME);
  localparam logic [HP_W-1:0]  HP_ONE     = HP_W'(1);
  localparam logic [HP_W-1:0]  HP_ZERO    = HP_W'(0);
  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(TICK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE    = DIV_W'(1);
  localparam logic [DIV_W-1:0] DIV_ZERO   = DIV_W'(0);
  localparam logic [13:0]      TIME_MAX   = 14'h3FFF;
  localparam logic [13:0]      LISTEN_END = 14'(LISTEN_LEN);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_BURST  = 2'd1,
    S_LISTEN = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  // TIME never wraps: it sticks at its maximum.
  function automatic logic [13:0] sat_inc(input logic [13:0] v);
    logic [13:0] r;
    if (v == TIME_MAX) begin
      r = v;
    end else begin
      r = v + 14'd1;
    end
    return r;
  endfunction

  // Sequencing state
  state_t            state_q,     state_d;
  logic [HP_W-1:0]   half_cnt_q,  half_cnt_d;   // clock index within a half-period
  logic              phase_q,     phase_d;      // 0: P half, 1: N half
  logic [4:0]        pulse_cnt_q, pulse_cnt_d;  // completed pulses in this burst
  logic [4:0]        burst_len_q, burst_len_d;  // pulses requested at START
  logic [DIV_W-1:0]  div_q,       div_d;        // sample-tick divider
  logic [13:0]       time_q,      time_d;

  // Output flops
  logic tx_p_q,        tx_p_d;
  logic tx_n_q,        tx_n_d;
  logic tx_active_q,   tx_active_d;
  logic busy_q,        busy_d;
  logic sample_tick_q, sample_tick_d;
  logic done_q,        done_d;

  // Helpers
  logic        busy_s;
  logic        tick_s;
  logic        start_s;
  logic [13:0] time_inc_s;

  // Next-state logic: cycle start, burst pulse timing, listen window and time base.
  always_comb begin
    state_d       = state_q;
    half_cnt_d    = half_cnt_q;
    phase_d       = phase_q;
    pulse_cnt_d   = pulse_cnt_q;
    burst_len_d   = burst_len_q;
    div_d         = div_q;
    time_d        = time_q;
    sample_tick_d = 1'b0;

    busy_s     = (state_q == S_BURST) || (state_q == S_LISTEN);
    tick_s     = busy_s && (div_q == DIV_LAST);
    time_inc_s = sat_inc(time_q);
    // A restart from DONE and a START from IDLE are the same single event.
    start_s    = ((state_q == S_IDLE) && START) ||
                 ((state_q == S_DONE) && AUTO_REPEAT);

    if (start_s) begin
      burst_len_d = BURST_LEN;
      half_cnt_d  = HP_ZERO;
      phase_d     = 1'b0;
      pulse_cnt_d = 5'd0;
      div_d       = DIV_ZERO;
      time_d      = 14'd0;
      // An empty burst goes straight to listening.
      if (BURST_LEN == 5'd0) begin
        state_d = S_LISTEN;
      end else begin
        state_d = S_BURST;
      end
    end else begin
      // Time base only runs while a cycle is in progress.
      if (tick_s) begin
        div_d         = DIV_ZERO;
        time_d        = time_inc_s;
        sample_tick_d = 1'b1;
      end else if (busy_s) begin
        div_d = div_q + DIV_ONE;
      end else begin
        div_d = div_q;
      end

      case (state_q)
        S_IDLE: begin
          state_d = S_IDLE;
        end
        S_BURST: begin
          if (half_cnt_q == HP_LAST) begin
            half_cnt_d = HP_ZERO;
            phase_d    = ~phase_q;
            // A pulse is complete at the end of its N half.
            if (phase_q) begin
              if (pulse_cnt_q == (burst_len_q - 5'd1)) begin
                pulse_cnt_d = 5'd0;
                state_d     = S_LISTEN;
              end else begin
                pulse_cnt_d = pulse_cnt_q + 5'd1;
              end
            end else begin
              pulse_cnt_d = pulse_cnt_q;
            end
          end else begin
            half_cnt_d = half_cnt_q + HP_ONE;
          end
        end
        S_LISTEN: begin
          // ">=" lets a window shorter than the burst close on the first tick.
          if (tick_s && (time_inc_s >= LISTEN_END)) begin
            state_d = S_DONE;
          end else begin
            state_d = S_LISTEN;
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // Output decode from next-state values so registered outputs match the new state.
  always_comb begin
    tx_active_d = (state_d == S_BURST);
    busy_d      = (state_d == S_BURST) || (state_d == S_LISTEN);
    done_d      = (state_d == S_DONE);
    // Dead time occupies the first DEAD_TIME clocks of every half-period.
    tx_p_d      = tx_active_d && !phase_d && (half_cnt_d >= DEAD_CNT);
    tx_n_d      = tx_active_d &&  phase_d && (half_cnt_d >= DEAD_CNT);
  end

  // Sequencer and output registers with synchronous reset.
  always_ff @(posedge SYS_CLK) begin
    if (RST) begin
      state_q       <= S_IDLE;
      half_cnt_q    <= HP_ZERO;
      phase_q       <= 1'b0;
      pulse_cnt_q   <= 5'd0;
      burst_len_q   <= 5'd0;
      div_q         <= DIV_ZERO;
      time_q        <= 14'd0;
      tx_p_q        <= 1'b0;
      tx_n_q        <= 1'b0;
      tx_active_q   <= 1'b0;
      busy_q        <= 1'b0;
      sample_tick_q <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      half_cnt_q    <= half_cnt_d;
      phase_q       <= phase_d;
      pulse_cnt_q   <= pulse_cnt_d;
      burst_len_q   <= burst_len_d;
      div_q         <= div_d;
      time_q        <= time_d;
      tx_p_q        <= tx_p_d;
      tx_n_q        <= tx_n_d;
      tx_active_q   <= tx_active_d;
      busy_q        <= busy_d;
      sample_tick_q <= sample_tick_d;
      done_q        <= done_d;
    end
  end

  assign TX_P        = tx_p_q;
  assign TX_N        = tx_n_q;
  assign TX_ACTIVE   = tx_active_q;
  assign BUSY        = busy_q;
  assign TIME        = time_q;
  assign SAMPLE_TICK = sample_tick_q;
  assign DONE        = done_q;

`ifdef TOF_CAPTURE_EN
  logic [13:0] tof_q,       tof_d;
  logic        tof_valid_q, tof_valid_d;
  logic        captured_q,  captured_d;   // a detection has been latched this cycle

  // First-detection capture; validity is published together with DONE.
  always_comb begin
    tof_d       = tof_q;
    tof_valid_d = tof_valid_q;
    captured_d  = captured_q;
    if (start_s) begin
      tof_d       = 14'd0;
      tof_valid_d = 1'b0;
      captured_d  = 1'b0;
    end else if (busy_s && DETECTION && !captured_q) begin
      tof_d      = time_q;
      captured_d = 1'b1;
    end else begin
      captured_d = captured_q;
    end
    if ((state_d == S_DONE) && captured_d) begin
      tof_valid_d = 1'b1;
    end else begin
      tof_valid_d = tof_valid_d & 1'b1;
    end
  end

  // Capture registers with synchronous reset.
  always_ff @(posedge SYS_CLK) begin
    if (RST) begin
      tof_q       <= 14'd0;
      tof_valid_q <= 1'b0;
      captured_q  <= 1'b0;
    end else begin
      tof_q       <= tof_d;
      tof_valid_q <= tof_valid_d;
      captured_q  <= captured_d;
    end
  end

  assign TOF       = tof_q;
  assign TOF_VALID = tof_valid_q;
`endif

endmodule

// File: tb/tb_tx_burst_sequencer.sv
// Testbench for tx_burst_sequencer (HALF_PERIOD=4, DEAD_TIME=1, TICK_DIV=5,
// LISTEN_LEN=20). The driver issues directed and random ranging cycles and
// pushes the per-cycle expected outputs, computed arithmetically from the
// cycle offset since START, into a scoreboard queue; an independent monitor
// pops and compares one entry after every clock edge.
module tb_tx_burst_sequencer;

  localparam int HP = 4;
  localparam int DT = 1;
  localparam int TD = 5;
  localparam int LL = 20;

  typedef struct {
    logic        p;
    logic        n;
    logic        act;
    logic        busy;
    logic        tick;
    logic        done;
    logic [13:0] tm;
    logic [13:0] tof;
    logic        tofv;
  } exp_t;

  logic        sys_clk     = 1'b0;
  logic        rst         = 1'b1;
  logic        start       = 1'b0;
  logic        auto_repeat = 1'b0;
  logic [4:0]  burst_len   = 5'd0;
  logic        tx_p, tx_n, tx_active, busy, sample_tick, done;
  logic [13:0] time_o;
`ifdef TOF_CAPTURE_EN
  logic        detection = 1'b0;
  logic [13:0] tof;
  logic        tof_valid;
`endif

  exp_t        exp_q[$];
  int          total     = 0;
  int          bad       = 0;
  int          done_seen = 0;
  int          done_exp  = 0;
  int          cyc       = 0;
  logic [13:0] last_time = 14'd0;
  logic [13:0] last_tof  = 14'd0;
  logic        last_tofv = 1'b0;
  bit          in_done   = 1'b0;

  always #5 sys_clk = ~sys_clk;

  tx_burst_sequencer #(
    .HALF_PERIOD(HP),
    .DEAD_TIME  (DT),
    .TICK_DIV   (TD),
    .LISTEN_LEN (LL)
  ) dut (
    .SYS_CLK    (sys_clk),
    .RST        (rst),
    .START      (start),
    .AUTO_REPEAT(auto_repeat),
    .BURST_LEN  (burst_len),
    .TX_P       (tx_p),
    .TX_N       (tx_n),
    .TX_ACTIVE  (tx_active),
    .BUSY       (busy),
    .TIME       (time_o),
    .SAMPLE_TICK(sample_tick),
    .DONE       (done)
`ifdef TOF_CAPTURE_EN
    ,
    .DETECTION  (detection),
    .TOF        (tof),
    .TOF_VALID  (tof_valid)
`endif
  );

  function automatic exp_t mk_zero();
    exp_t x;
    x.p = 1'b0; x.n = 1'b0; x.act = 1'b0; x.busy = 1'b0; x.tick = 1'b0;
    x.done = 1'b0; x.tm = 14'd0; x.tof = 14'd0; x.tofv = 1'b0;
    return x;
  endfunction

  function automatic exp_t mk_idle();
    exp_t x;
    x = mk_zero();
    x.tm = last_time; x.tof = last_tof; x.tofv = last_tofv;
    return x;
  endfunction

  // Expected outputs e clocks after the START edge of a burst of l pulses.
  function automatic exp_t mk_run(input int l, input int e, input int e_done);
    exp_t x;
    int   b, h, o;
    b = 2 * HP * l;
    h = e / HP;
    o = e % HP;
    x = mk_zero();
    x.act  = (e < b);
    x.p    = (e < b) && (h % 2 == 0) && (o >= DT);
    x.n    = (e < b) && (h % 2 == 1) && (o >= DT);
    x.busy = (e < e_done);
    x.tick = (e > 0) && (e % TD == 0);
    x.done = (e == e_done);
    x.tm   = (e / TD > 16383) ? 14'h3FFF : 14'(e / TD);
    return x;
  endfunction

  task automatic set_det(input bit d);
`ifdef TOF_CAPTURE_EN
    detection = d;
`else
    if (d) in_done = in_done;
`endif
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge sys_clk);
      rst = 1'b1; start = 1'b0; auto_repeat = 1'b0; set_det(1'b0);
      exp_q.push_back(mk_zero());
      @(posedge sys_clk);
    end
    last_time = 14'd0; last_tof = 14'd0; last_tofv = 1'b0; in_done = 1'b0;
  endtask

  task automatic idle(input int n, input logic st);
    for (int i = 0; i < n; i++) begin
      @(negedge sys_clk);
      rst = 1'b0; start = st; auto_repeat = 1'b0; set_det(1'b0);
      burst_len = 5'($urandom_range(0, 31));
      exp_q.push_back(mk_idle());
      @(posedge sys_clk);
    end
    in_done = 1'b0;
  endtask

  // One ranging cycle. via_auto: started by AUTO_REPEAT from DONE. abort_e:
  // RST lands on the edge that would produce offset abort_e (-1: never).
  // det_a/det_b: TIME values during which DETECTION pulses (-1: none).
  task automatic run(input int l, input bit hold, input bit via_auto,
                     input int abort_e, input int det_a, input int det_b);
    int   b, m, e_done, tof_t;
    bit   cap, det_s;
    exp_t x;
    b      = 2 * HP * l;
    m      = (TD * LL > b + 1) ? TD * LL : b + 1;
    e_done = ((m + TD - 1) / TD) * TD;
    cap    = 1'b0;
    tof_t  = 0;
    @(negedge sys_clk);
    rst = 1'b0; burst_len = 5'(l); set_det(1'b0);
    if (via_auto) begin
      auto_repeat = 1'b1; start = 1'($urandom_range(0, 1));
    end else begin
      auto_repeat = 1'b0; start = 1'b1;
    end
    exp_q.push_back(mk_run(l, 0, e_done));
    @(posedge sys_clk);
    for (int e = 1; e <= e_done; e++) begin
      @(negedge sys_clk);
      if (e == abort_e) begin
        rst = 1'b1; start = 1'b0; set_det(1'b0);
        exp_q.push_back(mk_zero());
        last_time = 14'd0; last_tof = 14'd0; last_tofv = 1'b0; in_done = 1'b0;
        @(posedge sys_clk);
        return;
      end
      start       = hold ? 1'b1 : 1'($urandom_range(0, 1));
      auto_repeat = 1'($urandom_range(0, 1));
      burst_len   = 5'($urandom_range(0, 31));
      det_s = ((e - 1) % TD == 2) &&
              (((e - 1) / TD == det_a) || ((e - 1) / TD == det_b));
      set_det(det_s);
      if (det_s && !cap) begin
        cap   = 1'b1;
        tof_t = (e - 1) / TD;
      end
      x      = mk_run(l, e, e_done);
      x.tof  = cap ? 14'(tof_t) : 14'd0;
      x.tofv = cap && (e == e_done);
      exp_q.push_back(x);
      @(posedge sys_clk);
    end
    last_time = 14'(e_done / TD);
    last_tof  = cap ? 14'(tof_t) : 14'd0;
    last_tofv = cap;
    in_done   = 1'b1;
    done_exp++;
  endtask

  // Monitor: one scoreboard comparison per clock edge, plus drive exclusivity.
  initial begin
    exp_t x;
    bit   ok;
    forever begin
      @(posedge sys_clk);
      #1;
      cyc++;
      total++;
      if (tx_p === 1'b1 && tx_n === 1'b1) begin
        bad++;
        $display("FAIL tx_excl cyc=%0d got TX_P=%b TX_N=%b need not both 1", cyc, tx_p, tx_n);
      end
      if (done === 1'b1) done_seen++;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        total++;
        ok = (tx_p === x.p) && (tx_n === x.n) && (tx_active === x.act) &&
             (busy === x.busy) && (sample_tick === x.tick) &&
             (done === x.done) && (time_o === x.tm);
`ifdef TOF_CAPTURE_EN
        ok = ok && (tof === x.tof) && (tof_valid === x.tofv);
`endif
        if (!ok) begin
          bad++;
          $display("FAIL cycle_chk cyc=%0d got p=%b n=%b act=%b busy=%b tick=%b done=%b time=%0d want p=%b n=%b act=%b busy=%b tick=%b done=%b time=%0d",
                   cyc, tx_p, tx_n, tx_active, busy, sample_tick, done, time_o,
                   x.p, x.n, x.act, x.busy, x.tick, x.done, x.tm);
`ifdef TOF_CAPTURE_EN
          $display("  tof cyc=%0d got tof=%0d valid=%b want tof=%0d valid=%b",
                   cyc, tof, tof_valid, x.tof, x.tofv);
`endif
        end
      end
    end
  end

  // Watchdog: the stimulus is bounded, this only guards against a stuck run.
  initial begin
    #3000000;
    $display("FAIL watchdog expired got no finish want finish");
    $fatal(1, "watchdog");
  end

  // Stimulus.
  initial begin
    int l, det_a, det_b;
    bit hold;
    do_reset(3);
    // Basic two-pulse burst.
    run(2, 1'b0, 1'b0, -1, -1, -1);
    idle(3, 1'b0);
    // Empty burst: listen only.
    run(0, 1'b0, 1'b0, -1, -1, -1);
    idle(2, 1'b0);
    // START held through the whole cycle and into DONE: exactly one cycle.
    run(2, 1'b1, 1'b0, -1, -1, -1);
    idle(1, 1'b1);
    idle(3, 1'b0);
    // Auto-repeat chain.
    run(1, 1'b0, 1'b0, -1, -1, -1);
    run(3, 1'b0, 1'b1, -1, -1, -1);
    run(0, 1'b1, 1'b1, -1, -1, -1);
    idle(3, 1'b0);
    // Reset mid-burst while TIME=1.
    run(2, 1'b0, 1'b0, 7, -1, -1);
    idle(4, 1'b0);
    // Burst longer than the listen window.
    run(31, 1'b0, 1'b0, -1, -1, -1);
    idle(2, 1'b0);
    run(13, 1'b0, 1'b0, -1, -1, -1);
    idle(2, 1'b0);
    // Detections at TIME=7 and TIME=12, then a run with none.
    run(2, 1'b0, 1'b0, -1, 7, 12);
    idle(2, 1'b0);
    run(2, 1'b0, 1'b0, -1, -1, -1);
    idle(2, 1'b0);
    // Randomized cycles.
    for (int i = 0; i < 14; i++) begin
      l     = int'($urandom_range(0, 31));
      hold  = 1'($urandom_range(0, 1));
      det_a = ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(0, 40));
      det_b = int'($urandom_range(0, 40));
      if (in_done && ($urandom_range(0, 1) == 1)) begin
        run(l, hold, 1'b1, -1, det_a, det_b);
      end else begin
        if (in_done) idle(1 + int'($urandom_range(0, 2)), 1'b0);
        run(l, hold, 1'b0, -1, det_a, det_b);
      end
    end
    idle(3, 1'b0);
    #3;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain got %0d entries left want 0", exp_q.size());
    end
    total++;
    if (done_seen != done_exp) begin
      bad++;
      $display("FAIL done_count got %0d want %0d", done_seen, done_exp);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
